wide_word_packer: RTL
=====================

# wide_word_packer

Upstream feeder for the 128-bit load-enabled holding register on the eFPGA interface path. It takes 32-bit beats from the Wishbone/logic-analyzer side and packs them little-endian into 128-bit words. A `in_last` marker closes a partial word early, zero-padded. Each completed word is presented on a valid/ready output, and a one-cycle `out_load` pulse drives the downstream register's enable directly.

## Interface
- `IN_WIDTH`, 32, beat width in bits.
- `BEATS`, 4, beats per output word; output width is `IN_WIDTH*BEATS` = 128.
- `CNT_W`, 2, beat-index width, equal to clog2(`BEATS`).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready` at a rising edge.
- `in_data`  in  32  beat payload.
- `in_last`  in  1  this beat closes the current word, even if it is partial.
- `out_valid`  out  1  packed word available.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  128  packed word; beat k occupies bits [32k+31:32k].
- `out_beats`  out  3  number of valid beats in `out_data`, range 1..4.
- `out_last`  out  1  word was closed by `in_last`.
- `out_load`  out  1  equals `out_valid & out_ready`; connects to the downstream register enable.

## Operation
- **State:**
  - beat index `cnt` (0..3);
  - assembly register `asm`, 96 bits, holding beats 0..2;
  - output register `out_data`/`out_beats`/`out_last`;
  - flag `out_valid`.
- **Ready rule:** `in_ready = ~out_valid | out_ready`. It is purely combinational from registered state and `out_ready`, and does not depend on `in_valid`.
- **Accepted beat, not closing** (`cnt < 3` and `~in_last`):
  - write `in_data` into slot `cnt` of `asm`;
  - `cnt <= cnt+1`.
- **Accepted beat, closing** (`cnt == 3` or `in_last`):
  - `out_data <= {zeros above slot cnt, in_data at slot cnt, asm slots below cnt}`;
  - `out_beats <= cnt+1`;
  - `out_last <= in_last`;
  - `out_valid <= 1`;
  - `cnt <= 0`;
  - clear `asm`.
- **Output consumed** (`out_load`) with no closing beat in the same cycle: `out_valid <= 0`. `out_data`, `out_beats` and `out_last` hold their old values.
- **Simultaneous `out_load` and closing beat:** the new word overwrites the output register and `out_valid` stays 1. There is no bubble.
- **Unused bits:** slots above the last valid beat are always zero, never stale data.
- **Wrap-around:** `cnt` never exceeds 3. `in_last` with `cnt == 3` closes a full word with `out_beats = 4` and `out_last = 1`.
- **Reset:** a mid-word reset discards the partial beats in `asm` and any pending output word.

## Timing
- **Reset values:**
  - `out_valid`, `out_load`, `out_last` = 0;
  - `out_data` = 0;
  - `out_beats` = 0;
  - `cnt` = 0 and `asm` = 0;
  - `in_ready` = 1 in the first cycle after reset.
- **Latency:** if the closing beat is accepted at edge N, `out_valid`, `out_data` and `out_beats` are valid from edge N (visible during cycle N+1). `out_load` can assert in that same cycle.
- **Throughput:** with `out_ready` held at 1, one word is produced every 4 accepted beats, with zero stall cycles.
- **Backpressure:** while `out_valid & ~out_ready`, `in_ready` = 0 and `out_data` is held stable. `in_valid`/`in_data` must be held by the source until accepted.
- **Reset priority:** `rst` has priority over every other input at an edge.

## Structure
- **Shared package** `efpga_if_pkg`:
  - `IN_WIDTH`, `BEATS`, `WORD_WIDTH` (128);
  - `CNT_W`;
  - typedef `beat_t` (32-bit);
  - typedef `word_t` (128-bit).
- **Sub-modules:** none; the block is a single module. The output register feeds the downstream enable register through `out_load`/`out_data`.

## Test plan
1. **Full word, no backpressure.**
   - Stimulus: after reset, `out_ready`=1, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444.
   - Required: one cycle after the 4th beat, `out_valid`=1, `out_data`=0x44444444_33333333_22222222_11111111, `out_beats`=4, `out_last`=0, and a single `out_load` pulse.
2. **Partial word closed by `in_last`.**
   - Stimulus: beats 0xAAAA0001, then 0xAAAA0002 with `in_last`=1.
   - Required: `out_data` = 64'h0 : 0xAAAA0002 : 0xAAAA0001, `out_beats`=2, `out_last`=1, and the next word starts at slot 0.
3. **Backpressure.**
   - Stimulus: `out_ready`=0, stream 8 beats 1..8.
   - Required: first word 4:3:2:1 is held; `in_ready` drops the cycle after beat 4; beats 5..8 stall.
   - Then raise `out_ready`: word 1 loads, beats 5..8 are accepted, and word 8:7:6:5 follows with no data loss or duplication.
4. **Back-to-back streaming.**
   - Stimulus: 12 continuous beats with `out_ready`=1.
   - Required: exactly 3 words and 3 `out_load` pulses spaced 4 cycles apart; `in_ready` never deasserts.
5. **Reset mid-word.**
   - Stimulus: 2 beats 0xDEAD0000 and 0xDEAD0001, then `rst` for 1 cycle, then beats 0x5..0x8.
   - Required: `out_valid`=0 during reset; the only word produced is 8:7:6:5; no 0xDEAD data appears.
6. **`in_last` on a full 4th beat with a simultaneous load.**
   - Stimulus: `in_last` on beat 4 while the previous word loads in the same cycle.
   - Required: `out_valid` stays 1, the new word has `out_beats`=4 and `out_last`=1, and `out_load` pulses once per word.

Source files
------------

// File: rtl/efpga_if_pkg.sv
// Shared widths and payload types for the eFPGA interface path.
// Beat and word sizes are fixed here so feeder and holding register agree.
package efpga_if_pkg;

    localparam int unsigned IN_WIDTH   = 32;
    localparam int unsigned BEATS      = 4;
    localparam int unsigned WORD_WIDTH = IN_WIDTH * BEATS;
    localparam int unsigned CNT_W      = $clog2(BEATS);
    localparam int unsigned BEATS_W    = $clog2(BEATS + 1);
    localparam int unsigned ASM_WIDTH  = IN_WIDTH * (BEATS - 1);

    typedef logic [IN_WIDTH-1:0]   beat_t;
    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [ASM_WIDTH-1:0]  asm_t;

    // Contents of the output holding stage
    typedef struct packed {
        logic               last;
        logic [BEATS_W-1:0] beats;
        word_t              data;
    } out_word_t;

endpackage

// File: rtl/wide_word_packer.sv
// Packs 32-bit beats little-endian into 128-bit words; in_last closes a word
// early with zero padding. out_load drives the downstream register enable.
module wide_word_packer
    import efpga_if_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [BEATS_W-1:0]    out_beats,
    output logic                  out_last,
    output logic                  out_load
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt;
    asm_t             asm_data;
    asm_t             asm_next;
    out_word_t        out_q;
    word_t            packed_word;
    logic             accept;
    logic             closing;

    // Output slot frees up in the same cycle it is consumed, so no bubble
    assign in_ready = ~out_valid | out_ready;
    assign out_load = out_valid & out_ready;
    assign accept   = in_valid & in_ready;
    assign closing  = (cnt == LAST_SLOT) | in_last;

    // Word as it would look if the current beat closes it; slots above cnt stay zero
    always_comb begin
        packed_word = '0;
        for (int k = 0; k < BEATS - 1; k++) begin
            if (CNT_W'(k) < cnt) begin
                packed_word[k*IN_WIDTH +: IN_WIDTH] = asm_data[k*IN_WIDTH +: IN_WIDTH];
            end
        end
        for (int k = 0; k < BEATS; k++) begin
            if (CNT_W'(k) == cnt) begin
                packed_word[k*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    // Assembly register with the current beat dropped into slot cnt
    always_comb begin
        asm_next = asm_data;
        for (int k = 0; k < BEATS - 1; k++) begin
            if (CNT_W'(k) == cnt) begin
                asm_next[k*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            asm_data  <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_load) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (closing) begin
                    out_q.data  <= packed_word;
                    out_q.beats <= BEATS_W'(cnt) + BEATS_W'(1);
                    out_q.last  <= in_last;
                    out_valid   <= 1'b1;
                    cnt         <= '0;
                    asm_data    <= '0;
                end else begin
                    asm_data <= asm_next;
                    cnt      <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_data  = out_q.data;
    assign out_beats = out_q.beats;
    assign out_last  = out_q.last;

endmodule
